apv_readout_arbiter: RTL

APV_READOUT_ARBITER -- requirements
Module: apv_readout_arbiter

---
 rtl/apv_pkg.sv | 17 +
 rtl/apv_ch_select.sv | 24 ++
 rtl/apv_readout_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/apv_pkg.sv
// Shared constants and FSM encoding for the APV readout arbiter.
package apv_pkg;

  localparam int unsigned APV_WORDS  = 130;
  localparam int unsigned APV_WORD_W = 13;
  localparam int unsigned CH_W       = 3;

  typedef enum logic [2:0] {
    StIdle,
    StWaitAll,
    StSelect,
    StRead,
    StMean,
    StDone
  } apv_state_e;

endpackage

// File: rtl/apv_ch_select.sv
// Lowest-index channel picker over the set of still-unserved masked channels.
module apv_ch_select
  import apv_pkg::*;
#(
  parameter int unsigned N_CH = 8
) (
  input  logic [N_CH-1:0] mask_i,
  output logic [CH_W-1:0] idx_o,
  output logic            none_o
);

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    idx_o  = '0;
    none_o = 1'b1;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o  = CH_W'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/apv_readout_arbiter.sv
// Serialises one complete APV event (130 words per masked channel) from per-channel
// FIFOs onto a single valid/ready stream, with frame-number and timeout checking.
module apv_readout_arbiter
  import apv_pkg::*;
#(
  parameter int unsigned N_CH    = 8,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                       CLK,
  input  logic                       RSTb,
  input  logic                       ENABLE,
  input  logic [N_CH-1:0]            CH_MASK,
  input  logic [N_CH-1:0]            CH_EVENT_READY,
  input  logic [N_CH-1:0]            CH_FIFO_EMPTY,
  input  logic [APV_WORD_W*N_CH-1:0] CH_FIFO_DATA,
  output logic [N_CH-1:0]            CH_FIFO_RD,
  output logic [N_CH-1:0]            CH_MEAN_RD,
  output logic [15:0]                OUT_DATA,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic                       OUT_FIRST,
  output logic                       OUT_LAST,
  output logic [23:0]                EVENT_COUNT,
  output logic                       BUSY,
  output logic                       TIMEOUT_ERR,
  output logic                       FRAME_ERR
);

  localparam int unsigned TW        = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  NUM_WORDS = 8'(APV_WORDS);
  localparam logic [7:0]  LAST_WORD = 8'(APV_WORDS - 1);

  apv_state_e            state_q, state_d;
  logic [N_CH-1:0]       mask_q, mask_d, served_q, served_d;
  logic [CH_W-1:0]       sel_q, sel_d;
  logic                  first_ch_q, first_ch_d, pending_q, pending_d;
  logic [7:0]            rd_cnt_q, rd_cnt_d, word_q, word_d, ref_q, ref_d;
  logic [TW-1:0]         empty_q, empty_d;
  logic [15:0]           out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d, out_first_q, out_first_d;
  logic                  out_last_q, out_last_d, to_err_q, to_err_d, fr_err_q, fr_err_d;
  logic [23:0]           evt_q, evt_d;

  logic [CH_W-1:0]       sel_idx;
  logic                  sel_none;
  logic [N_CH-1:0]       sel_oh;
  logic [APV_WORD_W-1:0] fifo_q;
  logic                  cur_empty, rd_fire, timeout_hit, last_word, xfer;

  apv_ch_select #(
    .N_CH(N_CH)
  ) u_sel (
    .mask_i(mask_q & ~served_q),
    .idx_o (sel_idx),
    .none_o(sel_none)
  );

  always_comb begin
    sel_oh    = '0;
    fifo_q    = '0;
    cur_empty = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_q == CH_W'(i)) begin
        sel_oh[i] = 1'b1;
        fifo_q    = CH_FIFO_DATA[i*APV_WORD_W +: APV_WORD_W];
        cur_empty = CH_FIFO_EMPTY[i];
      end
    end
  end

  assign xfer      = out_valid_q & OUT_READY;
  assign last_word = (word_q == LAST_WORD);
  assign rd_fire   = (state_q == StRead) && !cur_empty && !pending_q &&
                     (!out_valid_q || OUT_READY) && (rd_cnt_q < NUM_WORDS);
  // Trailer capture takes priority over a coincident timeout.
  assign timeout_hit = (state_q == StRead) && cur_empty && !(pending_q && last_word) &&
                       (empty_q == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (ENABLE && |CH_MASK) state_d = StWaitAll;
      StWaitAll: begin
        if (!ENABLE || CH_MASK == '0)                        state_d = StIdle;
        else if ((CH_EVENT_READY & CH_MASK) == CH_MASK)      state_d = StSelect;
      end
      StSelect:  state_d = sel_none ? StDone : StRead;
      StRead: begin
        if (pending_q && last_word) state_d = StMean;
        else if (timeout_hit)       state_d = StIdle;
      end
      StMean:    state_d = sel_none ? StDone : StSelect;
      StDone:    if (!out_valid_q || OUT_READY) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    mask_d      = mask_q;
    served_d    = served_q;
    sel_d       = sel_q;
    first_ch_d  = first_ch_q;
    pending_d   = pending_q;
    rd_cnt_d    = rd_cnt_q;
    word_d      = word_q;
    ref_d       = ref_q;
    empty_d     = empty_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    evt_d       = evt_q;
    to_err_d    = to_err_q | timeout_hit;
    fr_err_d    = fr_err_q;

    if (state_q == StWaitAll && state_d == StSelect) begin
      mask_d   = CH_MASK;
      served_d = '0;
    end
    if (state_q == StSelect) begin
      sel_d      = sel_idx;
      first_ch_d = (served_q == '0);
      rd_cnt_d   = '0;
      word_d     = '0;
      empty_d    = '0;
      for (int i = 0; i < N_CH; i++) begin
        if (sel_idx == CH_W'(i)) served_d[i] = 1'b1;
      end
    end
    if (rd_fire) begin
      pending_d = 1'b1;
      rd_cnt_d  = rd_cnt_q + 8'd1;
      empty_d   = '0;
    end else if (state_q == StRead && cur_empty) begin
      empty_d = empty_q + TW'(1);
    end

    if (xfer) begin
      out_valid_d = 1'b0;
      out_first_d = 1'b0;
      out_last_d  = 1'b0;
    end
    // A pending word is only ever captured into an empty output register.
    if (pending_q) begin
      pending_d   = 1'b0;
      out_data_d  = {sel_q, fifo_q};
      out_valid_d = 1'b1;
      out_first_d = first_ch_q && (word_q == 8'd0);
      out_last_d  = sel_none && last_word;
      word_d      = word_q + 8'd1;
      if (last_word) begin
        if (first_ch_q)                 ref_d    = fifo_q[7:0];
        else if (fifo_q[7:0] != ref_q)  fr_err_d = 1'b1;
      end
    end

    if (state_q == StDone && state_d == StIdle) evt_d = evt_q + 24'd1;
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      mask_q      <= '0;
      served_q    <= '0;
      sel_q       <= '0;
      first_ch_q  <= 1'b0;
      pending_q   <= 1'b0;
      rd_cnt_q    <= '0;
      word_q      <= '0;
      ref_q       <= '0;
      empty_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      evt_q       <= '0;
      to_err_q    <= 1'b0;
      fr_err_q    <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      served_q    <= served_d;
      sel_q       <= sel_d;
      first_ch_q  <= first_ch_d;
      pending_q   <= pending_d;
      rd_cnt_q    <= rd_cnt_d;
      word_q      <= word_d;
      ref_q       <= ref_d;
      empty_q     <= empty_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      evt_q       <= evt_d;
      to_err_q    <= to_err_d;
      fr_err_q    <= fr_err_d;
    end
  end

  always_comb begin
    CH_FIFO_RD  = rd_fire ? sel_oh : '0;
    CH_MEAN_RD  = (state_q == StMean) ? sel_oh : '0;
    BUSY        = (state_q != StIdle);
    OUT_DATA    = out_data_q;
    OUT_VALID   = out_valid_q;
    OUT_FIRST   = out_first_q;
    OUT_LAST    = out_last_q;
    EVENT_COUNT = evt_q;
    TIMEOUT_ERR = to_err_q;
    FRAME_ERR   = fr_err_q;
  end

endmodule
